// File: rtl/hcode_subshell_bridge.sv
// Multi-channel ap_fifo bridge across a PR boundary: per-channel inbound/outbound FIFOs and a decouple FSM.
// Define SUBSHELL_BRIDGE_STATS_EN to build the per-channel word counters.
module hcode_subshell_bridge #(
  parameter int DATA_W = 128,
  parameter int NCH    = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NCH*DATA_W-1:0] in_r_dout,
  input  logic [NCH-1:0]        in_r_empty_n,
  output logic [NCH-1:0]        in_r_read,
  output logic [NCH*DATA_W-1:0] ip_in_dout,
  output logic [NCH-1:0]        ip_in_empty_n,
  input  logic [NCH-1:0]        ip_in_read,
  input  logic [NCH*DATA_W-1:0] ip_out_din,
  output logic [NCH-1:0]        ip_out_full_n,
  input  logic [NCH-1:0]        ip_out_write,
  output logic [NCH*DATA_W-1:0] out_r_din,
  input  logic [NCH-1:0]        out_r_full,
  output logic [NCH-1:0]        out_r_write,
  input  logic                  decouple,
  output logic                  decouple_ack,
  output logic [NCH*CNT_W-1:0]  stat_in_cnt,
  output logic [NCH*CNT_W-1:0]  stat_out_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] out_empty;
  logic           flush;

  // Handshakes are held low during reset so no shell word is lost mid-reset.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [PTR_W-1:0]  in_wr, in_rd, out_wr, out_rd;
    logic [OCC_W-1:0]  in_cnt, out_cnt;
    logic              in_push, in_pop, out_push, out_pop;

    assign in_push  = ~ap_rst & in_r_empty_n[c] & (in_cnt < OCC_W'(DEPTH)) & ~decouple;
    assign in_pop   = ~ap_rst & ip_in_read[c] & (in_cnt != '0) & ~decouple;
    assign out_push = ~ap_rst & ip_out_write[c] & (out_cnt < OCC_W'(DEPTH)) & ~decouple;
    assign out_pop  = ~ap_rst & (out_cnt != '0) & ~out_r_full[c];

    assign in_r_read[c]     = in_push;
    assign ip_in_empty_n[c] = ~ap_rst & (in_cnt != '0) & ~decouple;
    assign ip_out_full_n[c] = ~ap_rst & (out_cnt < OCC_W'(DEPTH)) & ~decouple;
    assign out_r_write[c]   = out_pop;
    assign out_empty[c]     = (out_cnt == '0);

    assign ip_in_dout[c*DATA_W +: DATA_W] = in_mem[in_rd];
    assign out_r_din[c*DATA_W +: DATA_W]  = out_mem[out_rd];

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        // NOTE: the data arrays are reset too, so the exposed heads read 0 after reset.
        for (int i = 0; i < DEPTH; i++) in_mem[i] <= '0;
        in_wr  <= '0;
        in_rd  <= '0;
        in_cnt <= '0;
      end else if (flush) begin
        in_wr  <= '0;
        in_rd  <= '0;
        in_cnt <= '0;
      end else begin
        if (in_push) begin
          in_mem[in_wr] <= in_r_dout[c*DATA_W +: DATA_W];
          in_wr         <= in_wr + PTR_W'(1);
        end
        if (in_pop) in_rd <= in_rd + PTR_W'(1);
        if (in_push && !in_pop)      in_cnt <= in_cnt + OCC_W'(1);
        else if (!in_push && in_pop) in_cnt <= in_cnt - OCC_W'(1);
      end
    end

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        for (int i = 0; i < DEPTH; i++) out_mem[i] <= '0;
        out_wr  <= '0;
        out_rd  <= '0;
        out_cnt <= '0;
      end else begin
        if (out_push) begin
          out_mem[out_wr] <= ip_out_din[c*DATA_W +: DATA_W];
          out_wr          <= out_wr + PTR_W'(1);
        end
        if (out_pop) out_rd <= out_rd + PTR_W'(1);
        if (out_push && !out_pop)      out_cnt <= out_cnt + OCC_W'(1);
        else if (!out_push && out_pop) out_cnt <= out_cnt - OCC_W'(1);
      end
    end

`ifdef SUBSHELL_BRIDGE_STATS_EN
    logic [CNT_W-1:0] in_words, out_words;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        in_words  <= '0;
        out_words <= '0;
      end else begin
        if (in_push) in_words <= in_words + CNT_W'(1);
        if (out_pop) out_words <= out_words + CNT_W'(1);
      end
    end

    assign stat_in_cnt[c*CNT_W +: CNT_W]  = in_words;
    assign stat_out_cnt[c*CNT_W +: CNT_W] = out_words;
`else
    assign stat_in_cnt[c*CNT_W +: CNT_W]  = '0;
    assign stat_out_cnt[c*CNT_W +: CNT_W] = '0;
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: next state defaults to the current one so no latch is inferred.
    state_nxt = state;
    case (state)
      RUN:      if (decouple) state_nxt = DRAIN;
      DRAIN:    if (!decouple) state_nxt = RUN;
                else if (&out_empty) state_nxt = ISOLATED;
      ISOLATED: if (!decouple) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Inbound FIFOs are emptied on the single cycle that enters ISOLATED.
  assign flush        = (state == DRAIN) && (state_nxt == ISOLATED);
  assign decouple_ack = (state == ISOLATED);

endmodule

// File: doc/hcode_subshell_bridge.md
# hcode_subshell_bridge

Parametrised multi-channel stream bridge placed between the shell's ap_fifo ports and a partially-reconfigurable IP. Each of NCH channels carries an inbound FIFO (shell in_r → IP) and an outbound FIFO (IP → shell out_r), so no combinational path crosses the PR boundary. A decouple handshake drains outbound data and isolates the IP before reconfiguration. Optional per-channel word counters support bring-up and debug.

## Interface
Parameters:
- DATA_W, 128, word width per channel
- NCH, 4, channel count (1..8)
- DEPTH, 4, entries per FIFO; power of two, ≥2
- CNT_W, 32, statistics counter width

Ports:
- ap_clk  in  1  sole clock; all logic on its rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_r_dout  in  NCH*DATA_W  shell inbound data; channel c at [c*DATA_W +: DATA_W]
- in_r_empty_n  in  NCH  shell inbound word available
- in_r_read  out  NCH  pop shell inbound word
- ip_in_dout  out  NCH*DATA_W  inbound FIFO head to IP
- ip_in_empty_n  out  NCH  inbound FIFO non-empty
- ip_in_read  in  NCH  IP pops inbound head
- ip_out_din  in  NCH*DATA_W  IP outbound data
- ip_out_full_n  out  NCH  outbound FIFO has space
- ip_out_write  in  NCH  IP pushes outbound word
- out_r_din  out  NCH*DATA_W  outbound FIFO head to shell
- out_r_full  in  NCH  shell outbound full (active high)
- out_r_write  out  NCH  push word to shell
- decouple  in  1  request isolation of IP
- decouple_ack  out  1  IP isolated, outbound drained
- stat_in_cnt  out  NCH*CNT_W  words accepted from shell per channel
- stat_out_cnt  out  NCH*CNT_W  words delivered to shell per channel

## Operation
- Each FIFO: DEPTH-entry register array, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- Inbound push: in_r_read[c] = in_r_empty_n[c] & (in_cnt[c] < DEPTH) & ~decouple; word captured same edge.
- Inbound pop: ip_in_empty_n[c] = (in_cnt[c] != 0) & ~decouple; pop on ip_in_read[c] & ip_in_empty_n[c]; ip_in_read while empty_n low ignored.
- Outbound push: ip_out_full_n[c] = (out_cnt[c] < DEPTH) & ~decouple; ip_out_write ignored when full_n low.
- Outbound pop: out_r_write[c] = (out_cnt[c] != 0) & ~out_r_full[c]; continues during decouple.
- Simultaneous push and pop on same FIFO: count unchanged, both pointers advance. At full, push blocked even if pop occurs same cycle (no read-through to shell).
- Decouple FSM, states RUN, DRAIN, ISOLATED:
  - RUN → DRAIN when decouple=1.
  - DRAIN → ISOLATED when all outbound counts are 0; on entry all inbound FIFOs flushed (counts and pointers to 0).
  - DRAIN or ISOLATED → RUN when decouple=0.
  - decouple_ack = (state == ISOLATED), registered.
- Reset: all FIFOs empty, state RUN; every output 0 except data buses (head of zeroed array, 0).

## Timing
- Inbound latency: word read at edge t visible on ip_in_dout with ip_in_empty_n=1 from t+1.
- Outbound latency: word written at edge t presented with out_r_write=1 from t+1 if out_r_full=0.
- Throughput: one word per cycle per direction per channel, sustained.
- decouple_ack rises one cycle after the last outbound word leaves; falls one cycle after decouple drops.
- Reset mid-transfer: all buffered data discarded; in-flight shell words not popped.

## Configuration
- SUBSHELL_BRIDGE_STATS_EN defined: per-channel CNT_W-bit counters increment on each in_r_read and each out_r_write; wrap modulo 2^CNT_W; cleared by ap_rst only.
- Undefined: no counters synthesised; stat_in_cnt and stat_out_cnt tied to 0.

## Test plan
- Single word 0x0123..CDEF on channel 2, IP reads immediately → ip_in_dout matches at t+1; other channels' in_r_read stay 0.
- Shell streams 16 words, IP stalls → in_r_read drops after DEPTH=4 words; release → remaining 12 arrive in order, no loss/duplication.
- IP writes 8 words, out_r_full held 1 for 10 cycles → ip_out_full_n low after 4 words; on release out_r_write back-to-back, order preserved.
- Outbound holding 3 words, inbound 2, assert decouple → ip_* handshakes blocked, 3 words drained, decouple_ack=1 one cycle later, inbound counts 0; deassert → ack 0 next cycle.
- Reset asserted with both FIFOs full → all handshake outputs 0 next cycle, empty_n low, stats 0.
- With STATS_EN, CNT_W=4, 17 words through channel 0 → stat_in_cnt[0]=1, stat_out_cnt[0]=1 (wrap).
